// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among N_REQ req/ack requesters.
// Optional FIFO_ARB_FULL_GATE_EN: no new grant starts while the FIFO reports full.
module fifo_push_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned L2N   = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       ack,
  output logic                   push_req,
  output logic [WIDTH-1:0]       data_in,
  input  logic                   push_ack,
  input  logic                   full,
  output logic                   grant_vld,
  output logic [L2N-1:0]         grant_idx,
  output logic [15:0]            push_cnt
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           r_state;
  logic             r_push_req;
  logic [L2N-1:0]   r_rr_ptr;
  logic [L2N-1:0]   r_grant_idx;
  logic [WIDTH-1:0] r_data;
  logic [15:0]      r_push_cnt;

  logic             w_gate;
  logic             w_done;
  logic [N_REQ-1:0] w_grant_oh;
  logic [N_REQ-1:0] w_elig;
  logic [L2N-1:0]   w_base;
  logic [L2N-1:0]   w_cand;
  logic             w_win_vld;
  logic [L2N-1:0]   w_win_idx;
  logic [WIDTH-1:0] w_win_data;

`ifdef FIFO_ARB_FULL_GATE_EN
  assign w_gate = ~full;
`else
  assign w_gate = 1'b1;
`endif

  assign w_done     = (r_state == StBusy) && push_ack;
  assign w_grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant_idx;

  // On completion the search restarts after the grantee, which is masked out.
  assign w_base = w_done ? r_grant_idx : r_rr_ptr;
  assign w_elig = req & (w_done ? ~w_grant_oh : {N_REQ{1'b1}}) & {N_REQ{w_gate}};

  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_cand    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_cand = L2N'((32'(w_base) + k) % N_REQ);
      if (!w_win_vld && w_elig[w_cand]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_cand;
      end
    end
  end

  assign w_win_data = req_data[w_win_idx*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_push_req  <= 1'b0;
      r_rr_ptr    <= L2N'(N_REQ - 1);
      r_grant_idx <= '0;
      r_data      <= '0;
      r_push_cnt  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_win_vld) begin
            r_state     <= StBusy;
            r_push_req  <= 1'b1;
            r_grant_idx <= w_win_idx;
            r_data      <= w_win_data;
          end
        end
        StBusy: begin
          if (push_ack) begin
            r_rr_ptr   <= r_grant_idx;
            r_push_cnt <= r_push_cnt + 16'd1;
            if (w_win_vld) begin
              r_grant_idx <= w_win_idx;
              r_data      <= w_win_data;
            end else begin
              r_state    <= StIdle;
              r_push_req <= 1'b0;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // A reset cycle abandons the grant, so no ack may escape during it.
  assign ack       = (r_state == StBusy && push_ack && resetn) ? w_grant_oh : '0;
  assign push_req  = r_push_req;
  assign grant_vld = r_push_req;
  assign grant_idx = r_grant_idx;
  assign data_in   = r_data;
  assign push_cnt  = r_push_cnt;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: directed vector table, corner sequences, random vs model.
module tb_fifo_push_arbiter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  ack;
  logic        push_req;
  logic [3:0]  data_in;
  logic        push_ack;
  logic        full;
  logic        grant_vld;
  logic [1:0]  grant_idx;
  logic [15:0] push_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fifo_push_arbiter #(.N_REQ(4), .WIDTH(4), .L2N(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .push_req  (push_req),
    .data_in   (data_in),
    .push_ack  (push_ack),
    .full      (full),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx),
    .push_cnt  (push_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic [3:0] req;
    logic       pa;
    logic       e_preq;
    int         e_idx;   // -1: no grant, idx/data not checked
    logic [3:0] e_ack;
    int         e_cnt;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rstn, input logic [3:0] r, input logic [15:0] d,
                      input logic pa, input logic f);
    @(posedge clk);
    #1;
    resetn   = rstn;
    req      = r;
    req_data = d;
    push_ack = pa;
    full     = f;
    @(negedge clk);
  endtask

  // Behavioural model: owner is the requester holding the push port, -1 when free.
  int         m_owner;
  int         m_last;
  int         m_cnt;
  logic [3:0] m_data;

  function automatic int pick(input logic [3:0] elig, input int from);
    for (int k = 1; k <= N; k++) begin
      if (elig[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] gate_mask(input logic f);
`ifdef FIFO_ARB_FULL_GATE_EN
    return f ? 4'h0 : 4'hF;
`else
    return (f === 1'bx) ? 4'h0 : 4'hF;
`endif
  endfunction

  task automatic model_update(input logic rstn, input logic [3:0] r, input logic [15:0] d,
                              input logic pa, input logic f);
    int w;
    if (!rstn) begin
      m_owner = -1;
      m_last  = N - 1;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      w = pick(r & gate_mask(f), m_last);
      if (w >= 0) begin
        m_owner = w;
        m_data  = d[w*4 +: 4];
      end
    end else if (pa) begin
      m_cnt  = (m_cnt + 1) % 65536;
      m_last = m_owner;
      w = pick(r & ~(4'(1 << m_owner)) & gate_mask(f), m_owner);
      m_owner = w;
      if (w >= 0) m_data = d[w*4 +: 4];
    end
  endtask

  logic [15:0] fixed_data;
  logic [15:0] a_data;
  logic [3:0]  a_req;
  logic [3:0]  e_ack;
  logic        r_rstn;
  logic        r_pa;
  logic        r_full;

  initial begin
    fixed_data = 16'h3A5C;
    resetn = 1'b0; req = 4'b1111; req_data = fixed_data; push_ack = 1'b0; full = 1'b0;

    tbl[0]  = '{1'b0, 4'b1111, 1'b0, 1'b0, -1, 4'b0000, 0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b1, 1'b0, -1, 4'b0000, 0};
    tbl[2]  = '{1'b1, 4'b1111, 1'b1, 1'b0, -1, 4'b0000, 0};
    tbl[3]  = '{1'b1, 4'b1111, 1'b1, 1'b1,  0, 4'b0001, 0};
    tbl[4]  = '{1'b1, 4'b1111, 1'b1, 1'b1,  1, 4'b0010, 1};
    tbl[5]  = '{1'b1, 4'b1111, 1'b1, 1'b1,  2, 4'b0100, 2};
    tbl[6]  = '{1'b1, 4'b1111, 1'b1, 1'b1,  3, 4'b1000, 3};
    tbl[7]  = '{1'b1, 4'b1111, 1'b1, 1'b1,  0, 4'b0001, 4};
    tbl[8]  = '{1'b1, 4'b0010, 1'b1, 1'b1,  1, 4'b0010, 5};
    tbl[9]  = '{1'b1, 4'b0010, 1'b1, 1'b0, -1, 4'b0000, 6};
    tbl[10] = '{1'b1, 4'b0010, 1'b1, 1'b1,  1, 4'b0010, 6};
    tbl[11] = '{1'b1, 4'b0010, 1'b1, 1'b0, -1, 4'b0000, 7};
    tbl[12] = '{1'b1, 4'b0010, 1'b1, 1'b1,  1, 4'b0010, 7};
    tbl[13] = '{1'b1, 4'b0100, 1'b0, 1'b0, -1, 4'b0000, 8};
    tbl[14] = '{1'b1, 4'b0100, 1'b0, 1'b1,  2, 4'b0000, 8};
    tbl[15] = '{1'b1, 4'b0100, 1'b0, 1'b1,  2, 4'b0000, 8};
    tbl[16] = '{1'b1, 4'b0100, 1'b0, 1'b1,  2, 4'b0000, 8};
    tbl[17] = '{1'b1, 4'b0100, 1'b1, 1'b1,  2, 4'b0100, 8};
    tbl[18] = '{1'b1, 4'b0000, 1'b0, 1'b0, -1, 4'b0000, 9};
    tbl[19] = '{1'b1, 4'b0000, 1'b1, 1'b0, -1, 4'b0000, 9};

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rstn, tbl[i].req, fixed_data, tbl[i].pa, 1'b0);
      chk($sformatf("vec%0d_push_req", i), 32'(push_req), 32'(tbl[i].e_preq));
      chk($sformatf("vec%0d_grant_vld", i), 32'(grant_vld), 32'(tbl[i].e_preq));
      chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(tbl[i].e_ack));
      chk($sformatf("vec%0d_push_cnt", i), 32'(push_cnt), 32'(tbl[i].e_cnt));
      if (tbl[i].e_idx >= 0) begin
        chk($sformatf("vec%0d_grant_idx", i), 32'(grant_idx), 32'(tbl[i].e_idx));
        chk($sformatf("vec%0d_data_in", i), 32'(data_in), 32'(fixed_data[tbl[i].e_idx*4 +: 4]));
      end
    end

    // Reset in the middle of a grant to requester 3.
    step(1'b1, 4'b1000, fixed_data, 1'b0, 1'b0);
    step(1'b1, 4'b1000, fixed_data, 1'b0, 1'b0);
    chk("midrst_busy_push_req", 32'(push_req), 32'd1);
    chk("midrst_busy_idx", 32'(grant_idx), 32'd3);
    step(1'b0, 4'b1000, fixed_data, 1'b1, 1'b0);
    chk("midrst_no_ack", 32'(ack), 32'd0);
    step(1'b1, 4'b1111, fixed_data, 1'b0, 1'b0);
    chk("midrst_push_req_low", 32'(push_req), 32'd0);
    chk("midrst_cnt_clear", 32'(push_cnt), 32'd0);
    step(1'b1, 4'b1111, fixed_data, 1'b0, 1'b0);
    chk("midrst_regrant_vld", 32'(push_req), 32'd1);
    chk("midrst_regrant_idx", 32'(grant_idx), 32'd0);

    // Full-flag behaviour.
    step(1'b0, 4'b0000, fixed_data, 1'b0, 1'b0);
    step(1'b1, 4'b0001, fixed_data, 1'b0, 1'b1);
    chk("full_first_idle", 32'(push_req), 32'd0);
`ifdef FIFO_ARB_FULL_GATE_EN
    step(1'b1, 4'b0001, fixed_data, 1'b0, 1'b1);
    chk("full_gate_hold1", 32'(push_req), 32'd0);
    step(1'b1, 4'b0001, fixed_data, 1'b0, 1'b1);
    chk("full_gate_hold2", 32'(push_req), 32'd0);
    step(1'b1, 4'b0001, fixed_data, 1'b0, 1'b0);
    chk("full_drop_cycle", 32'(push_req), 32'd0);
    step(1'b1, 4'b0001, fixed_data, 1'b0, 1'b0);
    chk("full_drop_next", 32'(push_req), 32'd1);
    step(1'b1, 4'b0001, fixed_data, 1'b0, 1'b1);
    chk("full_busy_kept", 32'(push_req), 32'd1);
    step(1'b1, 4'b0001, fixed_data, 1'b1, 1'b1);
    chk("full_busy_ack", 32'(ack), 32'b0001);
    step(1'b1, 4'b0001, fixed_data, 1'b0, 1'b1);
    chk("full_no_rearb", 32'(push_req), 32'd0);
`else
    step(1'b1, 4'b0001, fixed_data, 1'b0, 1'b1);
    chk("nogate_push_while_full", 32'(push_req), 32'd1);
    chk("nogate_idx", 32'(grant_idx), 32'd0);
    step(1'b1, 4'b0001, fixed_data, 1'b1, 1'b1);
    chk("nogate_ack", 32'(ack), 32'b0001);
`endif

    // Randomised traffic against the model; requesters obey the hold-until-ack rule.
    a_req  = 4'b0000;
    a_data = 16'h0000;
    step(1'b0, a_req, a_data, 1'b0, 1'b0);
    model_update(1'b0, a_req, a_data, 1'b0, 1'b0);
    for (int c = 0; c < 400; c++) begin
      r_rstn = ($urandom_range(0, 59) != 0);
      r_pa   = ($urandom_range(0, 2) != 0);
      r_full = ($urandom_range(0, 3) == 0);
      step(r_rstn, a_req, a_data, r_pa, r_full);
      e_ack = (m_owner >= 0 && r_pa && r_rstn) ? 4'(1 << m_owner) : 4'b0000;
      chk($sformatf("rand%0d_push_req", c), 32'(push_req), 32'(m_owner >= 0));
      chk($sformatf("rand%0d_grant_vld", c), 32'(grant_vld), 32'(m_owner >= 0));
      chk($sformatf("rand%0d_ack", c), 32'(ack), 32'(e_ack));
      chk($sformatf("rand%0d_push_cnt", c), 32'(push_cnt), 32'(m_cnt));
      if (m_owner >= 0) begin
        chk($sformatf("rand%0d_grant_idx", c), 32'(grant_idx), 32'(m_owner));
        chk($sformatf("rand%0d_data_in", c), 32'(data_in), 32'(m_data));
      end
      model_update(r_rstn, a_req, a_data, r_pa, r_full);
      for (int i = 0; i < N; i++) begin
        if (e_ack[i]) begin
          if ($urandom_range(0, 2) == 0) a_req[i] = 1'b0;
          else a_data[i*4 +: 4] = 4'($urandom);
        end else if (!a_req[i] && $urandom_range(0, 3) == 0) begin
          a_req[i] = 1'b1;
          a_data[i*4 +: 4] = 4'($urandom);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
